// File: rtl/hdp_reg_sequencer.sv
// hdp_reg_sequencer
//   Command sequencer in front of the HDP-1280-2 SPI master. After reset it
//   replays a fixed power-up table of register writes, then serves single
//   host register read/write requests.
//
//   Host handshake: a request transfers on a rising edge where
//   req_valid && req_ready. req_ready is high only in IDLE. Once high,
//   req_valid is expected to stay high until that transfer edge.
//   Responses are a 1-cycle resp_valid pulse with no back-pressure.
//
//   Timing: the complete pulse counts as gap cycle 1. This puts resp_valid,
//   init_done and the next INIT_ISSUE exactly GAP_CYCLES after the complete
//   pulse. It also leaves GAP_CYCLES quiet cycles between a complete and
//   the next start pulse. error rises exactly TIMEOUT_CYCLES after the
//   start pulse when no complete arrives.
//
//   Optional feature macro: HDP_SEQ_READBACK_VERIFY_EN. When it is defined,
//   every init write is read back and compared, and a mismatch is fatal.
`timescale 1ns/1ps
module hdp_reg_sequencer #(
  parameter int WORD_WIDTH     = 8,
  parameter int NUM_INIT       = 4,
  parameter int GAP_CYCLES     = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic [NUM_INIT*2*WORD_WIDTH-1:0] init_table,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_rw,
  input  logic [WORD_WIDTH-2:0]          req_addr,
  input  logic [WORD_WIDTH-1:0]          req_wdata,
  output logic                           resp_valid,
  output logic [WORD_WIDTH-1:0]          resp_rdata,
  output logic                           init_done,
  output logic                           error,
  output logic                           spi_enable,
  output logic                           spi_start,
  output logic [WORD_WIDTH-1:0]          spi_tx_upper,
  output logic [WORD_WIDTH-1:0]          spi_tx_lower,
  input  logic [WORD_WIDTH-1:0]          spi_rx_lower,
  input  logic                           spi_complete,
  output logic [3:0]                     o_dbg_state
);

  localparam int WW      = WORD_WIDTH;
  localparam int MAX_CNT = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(MAX_CNT) + 1;
  localparam int IDX_W   = 4;

  // Gap dwell is one cycle shorter because the complete cycle is gap cycle 1.
  localparam logic [TW-1:0]    GAP_LAST = TW'(GAP_CYCLES - 2);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INIT - 1);

  typedef enum logic [3:0] {
    S_INIT_ISSUE = 4'd0,
    S_INIT_WAIT  = 4'd1,
    S_INIT_GAP   = 4'd2,
    S_IDLE       = 4'd3,
    S_HOST_WAIT  = 4'd4,
    S_HOST_GAP   = 4'd5,
    S_ERROR      = 4'd6
`ifdef HDP_SEQ_READBACK_VERIFY_EN
    ,
    S_INIT_VERIFY_WAIT = 4'd7,
    S_INIT_VERIFY_GAP  = 4'd8
`endif
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [TW-1:0]     r_timer;
  logic              r_rw;
  logic              r_spi_enable;
  logic              r_spi_start;
  logic [WW-1:0]     r_tx_upper;
  logic [WW-1:0]     r_tx_lower;
  logic              r_resp_valid;
  logic [WW-1:0]     r_resp_rdata;
  logic              r_init_done;
  logic              r_error;

  logic [2*WW-1:0]   w_entry;
  logic [TW-1:0]     w_timer_inc;

  // Current init entry as {addr_byte, data}.
  assign w_entry     = init_table[int'(r_idx)*2*WW +: 2*WW];
  // The timer saturates instead of wrapping.
  assign w_timer_inc = (&r_timer) ? r_timer : r_timer + TW'(1);

  assign req_ready    = (r_state == S_IDLE);
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign init_done    = r_init_done;
  assign error        = r_error;
  assign spi_enable   = r_spi_enable;
  assign spi_start    = r_spi_start;
  assign spi_tx_upper = r_tx_upper;
  assign spi_tx_lower = r_tx_lower;
  assign o_dbg_state  = r_state;

  // Sequencer FSM. Each transition clears the shared timer. Start and
  // response pulses default low, so each lasts exactly one cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_INIT_ISSUE;
      r_idx        <= '0;
      r_timer      <= '0;
      r_rw         <= 1'b0;
      r_spi_enable <= 1'b0;
      r_spi_start  <= 1'b0;
      r_tx_upper   <= '0;
      r_tx_lower   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_init_done  <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_spi_enable <= 1'b1;
      r_spi_start  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_timer      <= w_timer_inc;
      case (r_state)
        S_INIT_ISSUE: begin
          r_tx_upper  <= w_entry[2*WW-1:WW];
          r_tx_lower  <= w_entry[WW-1:0];
          r_spi_start <= 1'b1;
          r_timer     <= '0;
          r_state     <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          if (spi_complete) begin
            r_timer <= '0;
            r_state <= S_INIT_GAP;
          end else if (r_timer >= TMO_LAST) begin
            r_timer <= '0;
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_INIT_GAP: begin
          if (r_timer >= GAP_LAST) begin
            r_timer <= '0;
`ifdef HDP_SEQ_READBACK_VERIFY_EN
            r_tx_upper  <= {1'b1, w_entry[2*WW-2:WW]};
            r_tx_lower  <= '0;
            r_spi_start <= 1'b1;
            r_state     <= S_INIT_VERIFY_WAIT;
`else
            if (r_idx == IDX_LAST) begin
              r_init_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_INIT_ISSUE;
            end
`endif
          end
        end
`ifdef HDP_SEQ_READBACK_VERIFY_EN
        S_INIT_VERIFY_WAIT: begin
          if (spi_complete) begin
            r_timer <= '0;
            r_state <= S_INIT_VERIFY_GAP;
          end else if (r_timer >= TMO_LAST) begin
            r_timer <= '0;
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_INIT_VERIFY_GAP: begin
          // Rx data is settled once the gap has elapsed.
          if (r_timer >= GAP_LAST) begin
            r_timer <= '0;
            if (spi_rx_lower != w_entry[WW-1:0]) begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end else if (r_idx == IDX_LAST) begin
              r_init_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_INIT_ISSUE;
            end
          end
        end
`endif
        S_IDLE: begin
          if (req_valid) begin
            r_rw        <= req_rw;
            r_tx_upper  <= {req_rw, req_addr};
            r_tx_lower  <= req_rw ? '0 : req_wdata;
            r_spi_start <= 1'b1;
            r_timer     <= '0;
            r_state     <= S_HOST_WAIT;
          end
        end
        S_HOST_WAIT: begin
          if (spi_complete) begin
            r_timer <= '0;
            r_state <= S_HOST_GAP;
          end else if (r_timer >= TMO_LAST) begin
            r_timer <= '0;
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_HOST_GAP: begin
          if (r_timer >= GAP_LAST) begin
            r_resp_rdata <= r_rw ? spi_rx_lower : '0;
            r_resp_valid <= 1'b1;
            r_timer      <= '0;
            r_state      <= S_IDLE;
          end
        end
        S_ERROR: begin
          r_error <= 1'b1;
        end
        default: begin
          r_error <= 1'b1;
          r_timer <= '0;
          r_state <= S_ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdp_reg_sequencer.sv
// Testbench for hdp_reg_sequencer.
// The SPI model completes 200 clocks after each start pulse.
// Start-pulse bytes and responses are scoreboarded through expected queues.
`timescale 1ns/1ps
module tb_hdp_reg_sequencer;

  localparam int WW  = 8;
  localparam int NI  = 4;
  localparam int GAP = 128;
  localparam int TMO = 4096;
  localparam int LAT = 200;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  logic [NI*2*WW-1:0] init_table;
  logic               req_valid;
  logic               req_ready;
  logic               req_rw;
  logic [WW-2:0]      req_addr;
  logic [WW-1:0]      req_wdata;
  logic               resp_valid;
  logic [WW-1:0]      resp_rdata;
  logic               init_done;
  logic               error;
  logic               spi_enable;
  logic               spi_start;
  logic [WW-1:0]      spi_tx_upper;
  logic [WW-1:0]      spi_tx_lower;
  logic [WW-1:0]      spi_rx_lower;
  logic               spi_complete;
  logic [3:0]         dbg_state;

  hdp_reg_sequencer #(
    .WORD_WIDTH(WW), .NUM_INIT(NI), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .init_table(init_table),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .init_done(init_done), .error(error),
    .spi_enable(spi_enable), .spi_start(spi_start),
    .spi_tx_upper(spi_tx_upper), .spi_tx_lower(spi_tx_lower),
    .spi_rx_lower(spi_rx_lower), .spi_complete(spi_complete),
    .o_dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_complete_cyc = -1;
  int last_start_cyc    = 0;
  int n_starts = 0;
  int n_resp   = 0;
  logic prev_start = 1'b0;
  logic prev_resp  = 1'b0;
  logic       model_en = 1'b1;
  logic [7:0] model_rx = 8'h00;

  logic [2*WW-1:0] exp_q[$];
  logic [WW-1:0]   rsp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag, input logic [31:0] obs);
    n_chk++;
    n_err++;
    $error("FAIL %s: observed=%0h expected=none", tag, obs);
  endtask

  // ---------------- SPI master model ----------------
  initial begin
    int cnt;
    cnt = 0;
    spi_complete = 1'b0;
    spi_rx_lower = '0;
    forever begin
      @(negedge clk);
      spi_complete = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (cnt != 0) begin
        if (cnt == LAT) begin
          if (model_en) begin
            spi_complete      = 1'b1;
            spi_rx_lower      = model_rx;
            last_complete_cyc = cyc;
          end
          cnt = 0;
        end else begin
          cnt++;
        end
      end else if (spi_start) begin
        cnt = 1;
      end
    end
  end

  // ---------------- scoreboard: start pulses ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (spi_start) begin
        check("start_not_back_to_back", {31'd0, prev_start}, 32'd0);
        if (exp_q.size() == 0) fail_now("start_unexpected", {16'd0, spi_tx_upper, spi_tx_lower});
        else check("start_bytes", {16'd0, spi_tx_upper, spi_tx_lower}, {16'd0, exp_q.pop_front()});
        if (!init_done && last_complete_cyc > last_start_cyc)
          check("init_gap_to_next_start", cyc, last_complete_cyc + GAP + 1);
        last_start_cyc = cyc;
        n_starts++;
      end
      prev_start = spi_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  // ---------------- scoreboard: responses ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        check("resp_single_pulse", {31'd0, prev_resp}, 32'd0);
        if (rsp_q.size() == 0) fail_now("resp_unexpected", {24'd0, resp_rdata});
        else check("resp_rdata", {24'd0, resp_rdata}, {24'd0, rsp_q.pop_front()});
        check("resp_latency", cyc, last_complete_cyc + GAP);
        n_resp++;
      end
      prev_resp = resp_valid;
    end else begin
      prev_resp = 1'b0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic rw, input logic [WW-2:0] addr, input logic [WW-1:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wd;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    check("req_ready_accept", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 1000 && n_resp < target; i++) @(negedge clk);
    check("resp_seen", n_resp, target);
  endtask

`ifndef HDP_SEQ_READBACK_VERIFY_EN
  // Release reset (expected low on entry) and check the full init replay.
  task automatic run_init();
    int s0;
    s0 = n_starts;
    exp_q.push_back(16'h0044);
    exp_q.push_back(16'h0133);
    exp_q.push_back(16'h0222);
    exp_q.push_back(16'h0311);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("enable_after_release", {31'd0, spi_enable}, 32'd1);
    check("first_start_after_release", {31'd0, spi_start}, 32'd1);
    repeat (50) @(negedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 7'h7F;
    req_wdata = 8'hEE;
    repeat (20) @(negedge clk);
    check("ready_held_off_in_init", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
    check("init_done_set", {31'd0, init_done}, 32'd1);
    check("init_done_timing", cyc, last_complete_cyc + GAP);
    check("init_start_count", n_starts - s0, 4);
    check("init_queue_drained", exp_q.size(), 0);
  endtask
`endif

  // ---------------- directed sequence ----------------
  initial begin
    int s_save;
    int r_save;
    int err_cyc;
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    init_table = {16'h0311, 16'h0222, 16'h0133, 16'h0044};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_req_ready",  {31'd0, req_ready},  32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", {24'd0, resp_rdata}, 32'd0);
    check("rst_init_done",  {31'd0, init_done},  32'd0);
    check("rst_error",      {31'd0, error},      32'd0);
    check("rst_spi_enable", {31'd0, spi_enable}, 32'd0);
    check("rst_spi_start",  {31'd0, spi_start},  32'd0);
    check("rst_tx_bytes",   {16'd0, spi_tx_upper, spi_tx_lower}, 32'd0);

`ifndef HDP_SEQ_READBACK_VERIFY_EN
    // power-up table replay
    run_init();

    // host write
    exp_q.push_back(16'h05A5);
    rsp_q.push_back(8'h00);
    send_req(1'b0, 7'h05, 8'hA5);
    repeat (100) @(negedge clk);
    check("tx_held_during_wait", {16'd0, spi_tx_upper, spi_tx_lower}, 32'h05A5);
    wait_resp(1);

    // host read: tx_lower forced to 0 even with nonzero wdata
    model_rx = 8'h5A;
    exp_q.push_back(16'h8500);
    rsp_q.push_back(8'h5A);
    send_req(1'b1, 7'h05, 8'hFF);
    wait_resp(2);
    repeat (20) @(negedge clk);
    check("resp_rdata_held", {24'd0, resp_rdata}, 32'h5A);

    // timeout: model never completes
    model_en = 1'b0;
    exp_q.push_back(16'h1234);
    send_req(1'b0, 7'h12, 8'h34);
    err_cyc = -1;
    for (int i = 0; i < TMO + 200 && err_cyc < 0; i++) begin
      @(negedge clk);
      if (error) err_cyc = cyc;
    end
    check("timeout_error_set", {31'd0, error}, 32'd1);
    check("timeout_exact_cycle", err_cyc, last_start_cyc + TMO);
    s_save = n_starts;
    r_save = n_resp;
    repeat (300) @(negedge clk);
    check("error_ready_low", {31'd0, req_ready}, 32'd0);
    check("error_no_start",  n_starts, s_save);
    check("error_no_resp",   n_resp, r_save);
    check("error_sticky",    {31'd0, error}, 32'd1);

    // reset out of ERROR, init replays
    model_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("err_cleared_by_reset", {31'd0, error}, 32'd0);
    run_init();

    // read, then reset mid HOST_WAIT
    model_rx = 8'hC3;
    exp_q.push_back(16'hB300);
    rsp_q.push_back(8'hC3);
    send_req(1'b1, 7'h33, 8'h00);
    wait_resp(3);
    exp_q.push_back(16'h219C);
    send_req(1'b0, 7'h21, 8'h9C);
    repeat (50) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_spi_start",  {31'd0, spi_start},  32'd0);
    check("midrst_spi_enable", {31'd0, spi_enable}, 32'd0);
    check("midrst_tx_bytes",   {16'd0, spi_tx_upper, spi_tx_lower}, 32'd0);
    check("midrst_init_done",  {31'd0, init_done},  32'd0);
    check("midrst_resp_rdata", {24'd0, resp_rdata}, 32'd0);
    check("midrst_req_ready",  {31'd0, req_ready},  32'd0);
    run_init();

    // function restored after replay
    exp_q.push_back(16'h0A3C);
    rsp_q.push_back(8'h00);
    send_req(1'b0, 7'h0A, 8'h3C);
    wait_resp(4);
`else
    // readback of entry 0 returns 0xFF -> fatal mismatch
    model_rx = 8'hFF;
    exp_q.push_back(16'h0044);
    exp_q.push_back(16'h8000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3000 && !error; i++) @(negedge clk);
    check("verify_error_set",  {31'd0, error},     32'd1);
    check("verify_init_done",  {31'd0, init_done}, 32'd0);
    repeat (300) @(negedge clk);
    check("verify_start_count", n_starts, 2);
    check("verify_ready_low",  {31'd0, req_ready}, 32'd0);
`endif

    check("final_start_queue_empty", exp_q.size(), 0);
    check("final_resp_queue_empty",  rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
